// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: store/load op codes and the store RMW FSM states.
// Used by riscv_store_rmw (option macro STORE_MISALIGN_CHECK_EN) and riscv_store_merge.
package riscv_mem_pkg;

   localparam logic [1:0] ST_SB  = 2'd0;
   localparam logic [1:0] ST_SH  = 2'd1;
   localparam logic [1:0] ST_SW  = 2'd2;
   localparam logic [1:0] ST_ILL = 2'd3;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      DONE
   } st_state_t;

   function automatic logic misaligned(input logic [1:0] op, input logic [1:0] lane);
      return ((op == ST_SH) && lane[0]) || ((op == ST_SW) && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/riscv_store_merge.sv
// Combinational lane merge for sub-word stores: drops the byte/half of wdata into the
// old memory word at the lane selected by the low address bits.
module riscv_store_merge
   import riscv_mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  st_op,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (st_op)
         ST_SB:   merged[{lane, 3'b000} +: 8]     = wdata[7:0];
         // Half lane uses addr[1] only; addr[0] is either rejected or truncated upstream.
         ST_SH:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         ST_SW:   merged = wdata;
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/riscv_store_rmw.sv
// Store unit for a word-wide data memory without byte enables: SB/SH via read-modify-write,
// SW as a direct write. Define STORE_MISALIGN_CHECK_EN to reject misaligned SH/SW.
module riscv_store_rmw
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned RD_LATENCY = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        st_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_rd_en,
   input  logic [31:0]       dm_rdata,
   output logic              dm_we,
   output logic [31:0]       dm_wdata
);

   localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

   st_state_t   state, state_n;
   logic [1:0]  op_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [1:0]  cnt;
   logic        accept;
   logic        reject;
   logic [31:0] merged;

   // req_ready is registered from state_n == IDLE, so it already implies state == IDLE.
   assign accept = req_valid && req_ready;

   always_comb begin
      reject = (st_op == ST_ILL);
`ifdef STORE_MISALIGN_CHECK_EN
      reject = reject || misaligned(st_op, addr[1:0]);
`endif
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (reject)              state_n = DONE;
               else if (st_op == ST_SW) state_n = WRITE;
               else                     state_n = READ;
            end
         end
         READ:    state_n = WAIT;
         WAIT:    if (cnt == 2'd0) state_n = WRITE;
         WRITE:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   riscv_store_merge u_merge (
      .old_word (dm_rdata),
      .wdata    (wdata_q),
      .st_op    (op_q),
      .lane     (lane_q),
      .merged   (merged)
   );

   // Strobes are registered copies of the next-state decode, so at most one is high per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         dm_rd_en  <= 1'b0;
         dm_we     <= 1'b0;
         dm_addr   <= '0;
         dm_wdata  <= '0;
         op_q      <= ST_SB;
         lane_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         req_ready <= (state_n == IDLE);
         dm_rd_en  <= (state_n == READ);
         dm_we     <= (state_n == WRITE);
         done      <= (state_n == DONE);
         err       <= accept && reject;

         if (accept) begin
            op_q    <= st_op;
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            dm_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (!reject && (st_op == ST_SW)) dm_wdata <= wdata;
         end

         if (state == READ)                       cnt <= CNT_INIT;
         else if ((state == WAIT) && (cnt != 2'd0)) cnt <= cnt - 2'd1;

         if ((state == WAIT) && (cnt == 2'd0)) dm_wdata <= merged;
      end
   end

endmodule

// File: tb/tb_riscv_store_rmw.sv
// Bench for riscv_store_rmw: two instances (RD_LATENCY 1 and 3) share stimulus; a memory
// model answers reads with the configured latency and a byte-lane reference predicts writes.
module tb_riscv_store_rmw;

   localparam int LAT [2] = '{1, 3};

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  st_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  req_ready;
   logic [1:0]  done;
   logic [1:0]  err;
   logic [1:0]  dm_rd_en;
   logic [1:0]  dm_we;
   logic [31:0] dm_addr  [2];
   logic [31:0] dm_wdata [2];
   logic [31:0] dm_rdata [2];

   riscv_store_rmw #(.ADDR_W(32), .RD_LATENCY(1)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
      .st_op(st_op), .addr(addr), .wdata(wdata), .done(done[0]), .err(err[0]),
      .dm_addr(dm_addr[0]), .dm_rd_en(dm_rd_en[0]), .dm_rdata(dm_rdata[0]),
      .dm_we(dm_we[0]), .dm_wdata(dm_wdata[0])
   );

   riscv_store_rmw #(.ADDR_W(32), .RD_LATENCY(3)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
      .st_op(st_op), .addr(addr), .wdata(wdata), .done(done[1]), .err(err[1]),
      .dm_addr(dm_addr[1]), .dm_rd_en(dm_rd_en[1]), .dm_rdata(dm_rdata[1]),
      .dm_we(dm_we[1]), .dm_wdata(dm_wdata[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [2][64];
   logic        mon_en = 1'b0;
   int          rd_cnt [2] = '{0, 0};
   int          rd_cyc [2] = '{0, 0};
   logic        rd_pend [2] = '{1'b0, 1'b0};
   int          we_cnt [2] = '{0, 0};
   int          we_cyc [2] = '{0, 0};
   logic [31:0] we_addr [2];
   logic [31:0] we_data [2];
   int          done_cnt [2] = '{0, 0};
   int          done_cyc_log [2][512];
   logic        err_log [2][512];
   int          ovl_cnt [2] = '{0, 0};

   // Memory model and event recorder, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rd_pend[i] && (cyc == rd_cyc[i] + LAT[i])) begin
            dm_rdata[i] = mem[i][dm_addr[i][7:2]];
            rd_pend[i]  = 1'b0;
         end else begin
            dm_rdata[i] = $urandom;
         end
         if (mon_en) begin
            if (dm_rd_en[i]) begin
               rd_cnt[i]++;
               rd_cyc[i]  = cyc;
               rd_pend[i] = 1'b1;
            end
            if (dm_we[i]) begin
               we_cnt[i]++;
               we_cyc[i]  = cyc;
               we_addr[i] = dm_addr[i];
               we_data[i] = dm_wdata[i];
            end
            if (done[i]) begin
               done_cyc_log[i][done_cnt[i]] = cyc;
               err_log[i][done_cnt[i]]      = err[i];
               done_cnt[i]++;
            end
            if (($countones({dm_rd_en[i], dm_we[i], done[i]}) > 1) || (err[i] && !done[i]))
               ovl_cnt[i]++;
         end
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic model_reject(input logic [1:0] op, input logic [7:0] a);
      logic r;
      r = (op == 2'd3);
`ifdef STORE_MISALIGN_CHECK_EN
      r = r || ((op == 2'd1) && (a % 2 != 0)) || ((op == 2'd2) && (a % 4 != 0));
`endif
      return r;
   endfunction

   // Reference merge from byte arithmetic: which bytes of the old word the store replaces.
   function automatic logic [31:0] model_word(input logic [31:0] old, input logic [1:0] op,
                                              input logic [7:0] a, input logic [31:0] d);
      logic [7:0] b [4];
      int         k;
      for (int j = 0; j < 4; j++) b[j] = old[8*j +: 8];
      if (op == 2'd0) begin
         k    = int'(a % 4);
         b[k] = d[7:0];
      end else if (op == 2'd1) begin
         k        = 2 * int'((a / 2) % 2);
         b[k]     = d[7:0];
         b[k + 1] = d[15:8];
      end else begin
         return d;
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   task automatic wait_idle();
      int n = 0;
      while ((req_ready !== 2'b11) && (n < 50)) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_wait", {30'd0, req_ready}, 32'd3);
   endtask

   task automatic run_store(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
      int          b_rd [2], b_we [2], b_done [2], b_ovl [2];
      int          acc, lat, w;
      logic        rej;
      logic        rd_exp;
      logic [31:0] expw [2];
      wait_idle();
      rej    = model_reject(op, a);
      rd_exp = !rej && (op != 2'd2);
      w      = int'(a / 4);
      for (int i = 0; i < 2; i++) begin
         b_rd[i] = rd_cnt[i]; b_we[i] = we_cnt[i]; b_done[i] = done_cnt[i]; b_ovl[i] = ovl_cnt[i];
         expw[i] = model_word(mem[i][w], op, a, d);
      end
      st_op = op; addr = {24'd0, a}; wdata = d; req_valid = 1'b1;
      acc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0; st_op = 2'($urandom); addr = $urandom; wdata = $urandom;
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         lat = rej ? 1 : ((op == 2'd2) ? 2 : 3 + LAT[i]);
         check("done_count", 32'(done_cnt[i] - b_done[i]), 32'd1);
         check("done_latency", 32'(done_cyc_log[i][b_done[i]] - acc), 32'(lat));
         check("err", {31'd0, err_log[i][b_done[i]]}, {31'd0, rej});
         check("rd_count", 32'(rd_cnt[i] - b_rd[i]), {31'd0, rd_exp});
         if (rd_exp) check("rd_cycle", 32'(rd_cyc[i] - acc), 32'd1);
         check("we_count", 32'(we_cnt[i] - b_we[i]), {31'd0, !rej});
         if (!rej) begin
            check("we_cycle", 32'(we_cyc[i] - acc), 32'(lat - 1));
            check("we_addr", we_addr[i], {24'd0, a[7:2], 2'b00});
            check("we_data", we_data[i], expw[i]);
            mem[i][w] = expw[i];
         end
         check("strobe_overlap", 32'(ovl_cnt[i] - b_ovl[i]), 32'd0);
      end
   endtask

   initial begin
      int          b_we [2], b_done [2], b_rd [2];
      int          acc;
      logic [31:0] v;

      for (int w = 0; w < 64; w++) begin
         v = $urandom;
         mem[0][w] = v;
         mem[1][w] = v;
      end
      rst = 1'b1; req_valid = 1'b0; st_op = 2'd0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", {31'd0, req_ready[i]}, 32'd1);
         check("rst_strobes", {28'd0, done[i], err[i], dm_rd_en[i], dm_we[i]}, 32'd0);
         check("rst_dm_addr", dm_addr[i], 32'd0);
         check("rst_dm_wdata", dm_wdata[i], 32'd0);
      end
      rst = 1'b0;
      mon_en = 1'b1;

      // SB into 0xAABBCCDD at byte 2
      mem[0][4] = 32'hAABBCCDD; mem[1][4] = 32'hAABBCCDD;
      run_store(2'd0, 8'h12, 32'h00000055);
      check("sb_word", we_data[0], 32'hAA55CCDD);

      // SH upper half
      mem[0][8] = 32'h11223344; mem[1][8] = 32'h11223344;
      run_store(2'd1, 8'h22, 32'h0000BEEF);
      check("sh_word_l1", we_data[0], 32'hBEEF3344);
      check("sh_word_l3", we_data[1], 32'hBEEF3344);

      run_store(2'd2, 8'h30, 32'hCAFEF00D);
      check("sw_word", we_data[0], 32'hCAFEF00D);

      run_store(2'd1, 8'h41, 32'h00001234);
      run_store(2'd2, 8'h4B, 32'h87654321);
      run_store(2'd3, 8'h60, 32'hFFFFFFFF);

      // Illegal op held with req_valid, then an SW presented while the unit is in DONE.
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         b_we[i] = we_cnt[i]; b_done[i] = done_cnt[i]; b_rd[i] = rd_cnt[i];
      end
      st_op = 2'd3; addr = 32'h50; wdata = $urandom; req_valid = 1'b1;
      acc = cyc;
      @(posedge clk); #1;
      st_op = 2'd2; addr = 32'h34; wdata = 32'h0BADCAFE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("b2b_done_count", 32'(done_cnt[i] - b_done[i]), 32'd2);
         check("b2b_rej_latency", 32'(done_cyc_log[i][b_done[i]] - acc), 32'd1);
         check("b2b_rej_err", {31'd0, err_log[i][b_done[i]]}, 32'd1);
         check("b2b_sw_done", 32'(done_cyc_log[i][b_done[i] + 1] - acc), 32'd4);
         check("b2b_sw_err", {31'd0, err_log[i][b_done[i] + 1]}, 32'd0);
         check("b2b_we_count", 32'(we_cnt[i] - b_we[i]), 32'd1);
         check("b2b_we_cycle", 32'(we_cyc[i] - acc), 32'd3);
         check("b2b_we_data", we_data[i], 32'h0BADCAFE);
         check("b2b_rd_count", 32'(rd_cnt[i] - b_rd[i]), 32'd0);
         mem[i][13] = 32'h0BADCAFE;
      end

      // Reset pulse while both instances sit in WAIT.
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         b_we[i] = we_cnt[i]; b_done[i] = done_cnt[i];
      end
      st_op = 2'd0; addr = 32'h45; wdata = $urandom; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_ready", {30'd0, req_ready}, 32'd3);
      check("rstmid_strobes", {24'd0, dm_we, dm_rd_en, done, err}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rstmid_no_we", 32'(we_cnt[i] - b_we[i]), 32'd0);
         check("rstmid_no_done", 32'(done_cnt[i] - b_done[i]), 32'd0);
      end
      run_store(2'd0, 8'h45, 32'h000000A7);

      for (int n = 0; n < 40; n++)
         run_store(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
